// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   - IMEM_ADDR_WIDTH / IMEM_DATA_WIDTH : instruction memory geometry
//   - load_state_e                      : loader state encoding
//   - ERR_*                             : err_code values reported on failure
//   - is_receiving()                    : states in which a byte may be taken
package imem_loader_pkg;

  localparam int IMEM_ADDR_WIDTH = 12;
  localparam int IMEM_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_CSUM    = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } load_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  function automatic logic is_receiving(input load_state_e s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   rx_data/rx_valid/rx_ready : byte handshake, transfer on valid && ready
//   wr_en/wr_addr/wr_data     : one-cycle write strobe into instruction memory
// slave  : the loader (consumes bytes, drives the write port)
// master : the byte source / memory side (bench, UART receiver, instrmem)
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Receives an image
//   LEN_HI, LEN_LO, N x (INSTR_HI, INSTR_LO), CSUM
// assembles big-endian words, writes them to addresses 0..N-1 and releases
// the core only when the XOR checksum of all preceding bytes matches.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   restart    : one-cycle pulse, leaves DONE/ERROR for a fresh load
//   bus        : byte handshake in, instruction-memory write port out
//   cpu_hold   : core stalled (everywhere except DONE)
//   done       : image loaded and verified
//   error      : load failed, reason in err_code (01 length, 10 checksum)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int DATA_WIDTH = IMEM_DATA_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  imem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  load_state_e           state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            hi_q, hi_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;      // one extra bit so DEPTH is representable
  logic [7:0]            csum_q, csum_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [1:0]            err_code_q, err_code_d;

  logic        accept;
  logic [15:0] len_cat;

  // Only the registered ready is honoured, so bytes offered in DONE/ERROR
  // (or in the cycle right after reset) are silently dropped.
  assign accept  = bus.rx_valid && rx_ready_q;
  assign len_cat = {len_q[15:8], bus.rx_data};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    hi_d       = hi_q;
    cnt_d      = cnt_q;
    csum_d     = csum_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = bus.rx_data;
          csum_d      = csum_q ^ bus.rx_data;
          state_d     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_d  = len_cat;
          csum_d = csum_q ^ bus.rx_data;
          if (32'(len_cat) > 32'(DEPTH)) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_LEN;
          end else if (len_cat == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          hi_d    = bus.rx_data;
          csum_d  = csum_q ^ bus.rx_data;
          state_d = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
          wr_data_d = {hi_q, bus.rx_data};
          cnt_d     = cnt_q + 1'b1;
          csum_d    = csum_q ^ bus.rx_data;
          if (32'(cnt_q) + 32'd1 == 32'(len_q)) begin
            state_d = ST_CSUM;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      ST_DONE, ST_ERROR: begin
        if (restart) begin
          state_d    = ST_LEN_HI;
          len_d      = 16'd0;
          cnt_d      = '0;
          csum_d     = 8'd0;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = ST_LEN_HI;
    endcase

    // Status outputs are registered copies of the next state's decode so they
    // change in the same cycle as the state register.
    rx_ready_d = is_receiving(state_d);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LEN_HI;
      len_q      <= 16'd0;
      hi_q       <= 8'd0;
      cnt_q      <= '0;
      csum_q     <= 8'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rx_ready_q <= 1'b0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      cnt_q      <= cnt_d;
      csum_q     <= csum_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rx_ready_q <= rx_ready_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.rx_ready = rx_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign err_code     = err_code_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed byte images, expected
// memory writes queued by the stimulus, checked by an independent monitor.
module tb_imem_loader;

  logic       clk;
  logic       reset;
  logic       restart;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [1:0] err_code;

  imem_loader_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus ();

  imem_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .restart  (restart),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  img[$];
  int          total = 0;
  int          bad   = 0;

  // Instruction memory model fed by the loader's write port
  logic [15:0] mem   [4096];
  logic        wrote [4096];
  always @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr]   <= bus.wr_data;
      wrote[bus.wr_addr] <= 1'b1;
    end
  end

  // Scoreboard monitor: every observed write must match the queue head
  always @(negedge clk) begin
    if (bus.wr_en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0h data=%04h, required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%04h, required addr=%0h data=%04h",
                   bus.wr_addr, bus.wr_data, e.addr, e.data);
        end else begin
          $display("write addr=%0h data=%04h ok", bus.wr_addr, bus.wr_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic push_exp(input logic [11:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Called and returns at a falling edge; byte is taken at the rising edge
  // between the last ready sample and the return.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, required 1 (byte %02h)", b);
    end else begin
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_image(input int max_gap);
    foreach (img[i]) send_byte(img[i], (max_gap > 0) ? $urandom_range(max_gap, 0) : 0);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic [1:0] c, input logic h);
    @(negedge clk);
    chk({tag, "_done"},     {31'd0, done},     {31'd0, d});
    chk({tag, "_error"},    {31'd0, error},    {31'd0, e});
    chk({tag, "_err_code"}, {30'd0, err_code}, {30'd0, c});
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    chk({tag, "_pending"},  exp_q.size(),      32'd0);
  endtask

  task automatic load_good_image(input int max_gap);
    img = '{8'h00, 8'h02, 8'h05, 8'h09, 8'h01, 8'h01, 8'h0E};
    push_exp(12'd0, 16'h0509);
    push_exp(12'd1, 16'h0101);
    send_image(max_gap);
  endtask

  initial begin
    logic [7:0]  cs;
    logic [15:0] w;
    foreach (wrote[i]) wrote[i] = 1'b0;
    reset        = 1'b1;
    restart      = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("rst_wr_en",    {31'd0, bus.wr_en},    32'd0);
    chk("rst_wr_addr",  {20'd0, bus.wr_addr},  32'd0);
    chk("rst_wr_data",  {16'd0, bus.wr_data},  32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold},     32'd1);
    chk("rst_done",     {31'd0, done},         32'd0);
    chk("rst_error",    {31'd0, error},        32'd0);
    chk("rst_err_code", {30'd0, err_code},     32'd0);
    reset = 1'b0;

    // 1: good two-word image
    load_good_image(0);
    check_status("s1", 1'b1, 1'b0, 2'b00, 1'b0);
    chk("s1_mem0",   {16'd0, mem[0]},   32'h0509);
    chk("s1_mem1",   {16'd0, mem[1]},   32'h0101);
    chk("s1_wrote2", {31'd0, wrote[2]}, 32'd0);
    pulse_restart();

    // 2: checksum mismatch
    img = '{8'h00, 8'h02, 8'h05, 8'h09, 8'h01, 8'h01, 8'h0F};
    push_exp(12'd0, 16'h0509);
    push_exp(12'd1, 16'h0101);
    send_image(0);
    check_status("s2", 1'b0, 1'b1, 2'b10, 1'b1);
    pulse_restart();

    // 3: length 0x1001 too large
    img = '{8'h10, 8'h01};
    send_image(0);
    check_status("s3", 1'b0, 1'b1, 2'b01, 1'b1);
    pulse_restart();

    // 4: empty image
    img = '{8'h00, 8'h00, 8'h00};
    send_image(0);
    check_status("s4", 1'b1, 1'b0, 2'b00, 1'b0);

    // 5: good image with random gaps, then bytes offered while DONE
    pulse_restart();
    load_good_image(5);
    check_status("s5", 1'b1, 1'b0, 2'b00, 1'b0);
    bus.rx_data  = 8'hAA;
    bus.rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_status("s5_extra", 1'b1, 1'b0, 2'b00, 1'b0);
    pulse_restart();

    // 6a: reset after the fourth byte (first word already committed)
    img = '{8'h00, 8'h02, 8'h05, 8'h09};
    push_exp(12'd0, 16'h0509);
    send_image(0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("s6_rst_wr_en",    {31'd0, bus.wr_en},    32'd0);
    chk("s6_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    chk("s6_rst_cpu_hold", {31'd0, cpu_hold},     32'd1);
    reset = 1'b0;
    load_good_image(0);
    check_status("s6", 1'b1, 1'b0, 2'b00, 1'b0);

    // 6b: restart out of ERROR into a good load
    pulse_restart();
    img = '{8'h20, 8'h00};
    send_image(0);
    check_status("s6_err", 1'b0, 1'b1, 2'b01, 1'b1);
    pulse_restart();
    load_good_image(0);
    check_status("s6_recover", 1'b1, 1'b0, 2'b00, 1'b0);
    pulse_restart();

    // 7: full-depth image, len = 4096, last write at 4095
    img = '{8'h10, 8'h00};
    cs  = 8'h10;
    for (int i = 0; i < 4096; i++) begin
      w = {4'h0, 12'(i)};
      w = {w[11:4], w[7:0] ^ 8'h5A};
      img.push_back(w[15:8]);
      img.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
      push_exp(12'(i), w);
    end
    img.push_back(cs);
    send_image(0);
    check_status("s7", 1'b1, 1'b0, 2'b00, 1'b0);
    chk("s7_last_addr", {20'd0, bus.wr_addr}, 32'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader: the write side of the instruction memory. It accepts a byte stream (from the UART receiver or a bench driver) over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them to consecutive instruction-memory addresses from 0. It holds the DSP core in hold until the whole image is written and its checksum verifies. It replaces $readmemb preloading on hardware.

Parameters:
ADDR_WIDTH, 12, instruction memory address width; depth = 2**ADDR_WIDTH.
DATA_WIDTH, 16, instruction word width; fixed at 2 bytes per word.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
rx_data  input  8  incoming byte.
rx_valid  input  1  rx_data valid this cycle.
rx_ready  output  1  loader can accept a byte; transfer when rx_valid && rx_ready.
restart  input  1  one-cycle pulse; from DONE or ERROR return to LEN_HI for a new load.
wr_en  output  1  instruction-memory write strobe, one cycle per word.
wr_addr  output  ADDR_WIDTH  write address.
wr_data  output  DATA_WIDTH  write data.
cpu_hold  output  1  high while not in DONE; core stalled.
done  output  1  image loaded and checksum good.
error  output  1  load failed.
err_code  output  2  01 length too large, 10 checksum mismatch, 00 none.

Behaviour:
- Image format: LEN_HI, LEN_LO (word count N, big-endian), then N x (INSTR_HI, INSTR_LO), then CSUM = XOR of every preceding byte of the image.
- Reset values: rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, err_code=00, state=LEN_HI, word counter=0, checksum accumulator=0.
- rx_ready = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM; 0 in DONE and ERROR. It is 0 in the cycle immediately after reset.
- States:
  - LEN_HI: on a byte, latch len[15:8] and go to LEN_LO.
  - LEN_LO: on a byte, latch len[7:0]. If len > 2**ADDR_WIDTH, go to ERROR with err_code=01. If len == 0, go to CSUM. Otherwise go to DATA_HI.
  - DATA_HI: on a byte, latch the high byte and go to DATA_LO.
  - DATA_LO: on a byte, register the write for the next cycle and increment the word counter. If the counter reaches len, go to CSUM; else go to DATA_HI.
  - CSUM: on a byte, compare it with the accumulator. Match goes to DONE. Mismatch goes to ERROR with err_code=10.
  - DONE: done=1, cpu_hold=0. Stay until restart or reset.
  - ERROR: error=1, cpu_hold=1. Stay until restart or reset.
- Write timing: the cycle after the DATA_LO byte is accepted, wr_en=1 for exactly one cycle, with wr_data={hi,lo} and wr_addr = word index (0, 1, ...). wr_addr and wr_data hold their values when wr_en is 0.
- Checksum accumulator XORs every accepted byte before CSUM, including the length bytes. It is cleared on reset and on restart.
- Writes already performed before an ERROR are not undone. The core stays held.
- rx_valid with rx_ready=0: the byte is ignored and no state change occurs. Gaps of any length between bytes are legal.
- Boundary len == 2**ADDR_WIDTH (4096) is legal. The last write goes to address 4095; wr_addr is not wrapped into a new write.
- restart in a receiving state is ignored.
- Reset mid-load returns to the reset state, even if wr_en is pending. Memory contents are not touched by reset.

Decomposition:
- Shared package (dsp_pkg): loader state encoding constants, err_code constants, IMEM_ADDR_WIDTH=12, IMEM_DATA_WIDTH=16.
- No sub-module is required. The loader's write port ties to the instruction memory's write interface (instrmem gains wr_en/wr_addr/wr_data).

Test Plan:
1. Bytes 00 02 05 09 01 01 0E -> writes addr0=0x0509 and addr1=0x0101. done=1, cpu_hold=0. Reading instrmem addr 0 gives 0x0509 and addr 2 region is unaffected.
2. Same image with CSUM=0F -> both writes occur, then error=1, err_code=10, done=0, cpu_hold=1.
3. Bytes 10 01 -> error=1, err_code=01 right after LEN_LO. No wr_en pulses, and rx_ready=0 afterwards.
4. Bytes 00 00 00 -> no writes, done=1.
5. Scenario 1 with random 0-5-cycle rx_valid gaps, and rx_valid held high in DONE -> identical writes; extra bytes are ignored.
6. Reset asserted after byte 4 of scenario 1, then full scenario 1 re-sent -> recovers with done=1. restart from ERROR followed by a valid image also gives done=1.
